// File: rtl/idu_pipe.sv
// rtl/idu_pipe.sv - registered RV32I/RV64I decode stage with a two-entry skid buffer
// Decodes {inst, pc} plus same-cycle regfile data into EXU operands and control flags.
module idu_pipe #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [RAW-1:0]  rf_raddr1,
  output logic [RAW-1:0]  rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [XLEN-1:0] out_rs2data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_reg_wen,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_mem_ren,
  output logic            out_mem_wen,
  output logic            out_word,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_wen;
    logic            jump;
    logic            branch;
    logic            mem_ren;
    logic            mem_wen;
    logic            word;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d, dec;
  logic   accept, pop;

  logic [6:0] opc;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_opimm, is_op, is_opimm32, is_op32, is_writer;
  logic signed [31:0] imm32;

  assign rf_raddr1 = RAW'(in_inst[19:15]);
  assign rf_raddr2 = RAW'(in_inst[24:20]);

  assign opc        = in_inst[6:0];
  assign is_lui     = (opc == 7'b0110111);
  assign is_auipc   = (opc == 7'b0010111);
  assign is_jal     = (opc == 7'b1101111);
  assign is_jalr    = (opc == 7'b1100111);
  assign is_branch  = (opc == 7'b1100011);
  assign is_load    = (opc == 7'b0000011);
  assign is_store   = (opc == 7'b0100011);
  assign is_opimm   = (opc == 7'b0010011);
  assign is_op      = (opc == 7'b0110011);
  assign is_opimm32 = RV64 && (opc == 7'b0011011);
  assign is_op32    = RV64 && (opc == 7'b0111011);
  assign is_writer  = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op
                    | is_opimm32 | is_op32;

  // Immediate built at 32 bits, then sign-extended to XLEN by the signed size cast
  always_comb begin
    imm32 = '0;
    if (is_jalr || is_load || is_opimm || is_opimm32)
      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (is_store)
      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (is_branch)
      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm32 = {in_inst[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  end

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.imm      = XLEN'(imm32);
    dec.src1     = is_lui ? '0 : ((is_auipc || is_jal) ? in_pc : rf_rdata1);
    dec.src2     = (is_op || is_op32 || is_branch) ? rf_rdata2 : dec.imm;
    dec.rs2data  = rf_rdata2;
    dec.rd       = in_inst[11:7];
    dec.funct3   = in_inst[14:12];
    dec.funct7b5 = in_inst[30];
    dec.reg_wen  = is_writer && (in_inst[11:7] != 5'd0);
    dec.jump     = is_jal || is_jalr;
    dec.branch   = is_branch;
    dec.mem_ren  = is_load;
    dec.mem_wen  = is_store;
    dec.word     = is_opimm32 || is_op32;
    dec.illegal  = !(is_writer || is_branch || is_store);
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE:     if (accept && !pop) state_d = FULL;
                 else if (pop && !accept) state_d = EMPTY;
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // New entry lands in the head when the buffer is empty or the head leaves this cycle
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (!flush) begin
      if (state_q == FULL) begin
        if (pop) head_d = tail_q;
      end else if (accept && (state_q == EMPTY || pop)) begin
        head_d = dec;
      end else if (accept) begin
        tail_d = dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_pc       = head_q.pc;
  assign out_src1     = head_q.src1;
  assign out_src2     = head_q.src2;
  assign out_rs2data  = head_q.rs2data;
  assign out_imm      = head_q.imm;
  assign out_rd       = head_q.rd;
  assign out_funct3   = head_q.funct3;
  assign out_funct7b5 = head_q.funct7b5;
  assign out_reg_wen  = head_q.reg_wen;
  assign out_jump     = head_q.jump;
  assign out_branch   = head_q.branch;
  assign out_mem_ren  = head_q.mem_ren;
  assign out_mem_wen  = head_q.mem_wen;
  assign out_word     = head_q.word;
  assign out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// tb/tb_idu_pipe.sv - randomized bench for idu_pipe against a queue-based decode model
// Directed literal cases first, then random traffic with backpressure, flush and a mid-run reset.
module tb_idu_pipe;
  localparam int XLEN = 64;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready, out_valid;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic [63:0] out_pc, out_src1, out_src2, out_rs2data, out_imm;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_reg_wen, out_jump, out_branch, out_mem_ren, out_mem_wen;
  logic        out_word, out_illegal;

  logic [63:0] regs [32];
  logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b};
  int n_vec = 0, n_fail = 0;

  typedef struct {
    logic [63:0] pc, src1, src2, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7, wen, jump, br, ren, wr, word, ill;
  } exp_t;
  exp_t mq[$];

  idu_pipe #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2), .out_rs2data(out_rs2data),
    .out_imm(out_imm), .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_reg_wen(out_reg_wen), .out_jump(out_jump), .out_branch(out_branch),
    .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_word(out_word),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field layout, immediates via arithmetic shifts
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    int imm = 0;
    logic [6:0] op = i[6:0];
    logic [63:0] r1 = regs[i[19:15]];
    logic [63:0] r2 = regs[i[24:20]];
    bit lui = (op == 7'h37), auipc = (op == 7'h17), jal = (op == 7'h6f), jalr = (op == 7'h67);
    bit br = (op == 7'h63), ld = (op == 7'h03), st = (op == 7'h23), opi = (op == 7'h13);
    bit opr = (op == 7'h33), opi32 = (op == 7'h1b), op32 = (op == 7'h3b);
    bit writes = lui | auipc | jal | jalr | ld | opi | opr | opi32 | op32;
    if (jalr || ld || opi || opi32) imm = int'(i) >>> 20;
    else if (st) imm = ((int'(i) >>> 25) << 5) | int'(i[11:7]);
    else if (br) imm = ((int'(i) >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
    else if (lui || auipc) imm = int'(i & 32'hFFFFF000);
    else if (jal) imm = ((int'(i) >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
    e.pc   = pc;
    e.imm  = 64'(longint'(imm));
    e.src1 = lui ? 64'd0 : ((auipc || jal) ? pc : r1);
    e.src2 = (opr || op32 || br) ? r2 : e.imm;
    e.rs2  = r2;
    e.rd   = i[11:7];
    e.f3   = i[14:12];
    e.f7   = i[30];
    e.ill  = !(writes || br || st);
    e.wen  = writes && (i[11:7] != 0);
    e.jump = jal || jalr;
    e.br   = br;
    e.ren  = ld;
    e.wr   = st;
    e.word = opi32 || op32;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) mq.delete();
    else begin
      automatic bit acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) mq.delete(0);
      if (acc) mq.push_back(model(in_inst, in_pc));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, mq.size() < 2);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0 && out_valid) begin
        chk("pc", out_pc, mq[0].pc);
        chk("rs2data", out_rs2data, mq[0].rs2);
        chk("rd_f3_f7", {out_rd, out_funct3, out_funct7b5}, {mq[0].rd, mq[0].f3, mq[0].f7});
        chk("flags", {out_reg_wen, out_jump, out_branch, out_mem_ren, out_mem_wen, out_word, out_illegal},
            {mq[0].wen, mq[0].jump, mq[0].br, mq[0].ren, mq[0].wr, mq[0].word, mq[0].ill});
        if (!mq[0].ill) begin
          chk("src1", out_src1, mq[0].src1);
          chk("src2", out_src2, mq[0].src2);
          chk("imm", out_imm, mq[0].imm);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    in_inst = inst; in_pc = pc; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 64'd0 : {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", out_pc | out_src1 | out_imm, 0);
    chk("rst_flags", {out_reg_wen, out_jump, out_mem_wen, out_illegal}, 0);

    out_ready = 1'b1;
    issue(32'h00500093, 64'h100);
    chk("addi_valid", out_valid, 1); chk("addi_src1", out_src1, 0);
    chk("addi_imm", out_imm, 5); chk("addi_src2", out_src2, 5);
    chk("addi_rd", out_rd, 1); chk("addi_wen", out_reg_wen, 1);
    issue(32'h12345137, 64'h104);
    chk("lui_src1", out_src1, 0); chk("lui_src2", out_src2, 64'h12345000);
    issue(32'h80000137, 64'h108);
    chk("lui_neg_src2", out_src2, 64'hFFFFFFFF80000000);
    issue(32'hFFDFF0EF, 64'h80000010);
    chk("jal_src1", out_src1, 64'h80000010); chk("jal_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("jal_jump", out_jump, 1); chk("jal_wen", out_reg_wen, 1);
    issue(32'h0020A423, 64'h10C);
    chk("sw_wen", {out_mem_wen, out_reg_wen}, 2'b10); chk("sw_imm", out_imm, 8);
    chk("sw_rs2data", out_rs2data, regs[2]);
    issue(32'h00208863, 64'h110);
    chk("beq_branch", out_branch, 1); chk("beq_imm", out_imm, 16); chk("beq_src2", out_src2, regs[2]);
    issue(32'hFFF0819B, 64'h114);
    chk("addiw_word", out_word, 1); chk("addiw_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);

    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00500293; in_pc = 64'h200; @(negedge clk);
    in_inst = 32'h00600313; in_pc = 64'h204; @(negedge clk);
    in_inst = 32'h00700393; in_pc = 64'h208; @(negedge clk);
    chk("bp_full_ready", in_ready, 0); chk("bp_head", out_pc, 64'h200);
    out_ready = 1'b1; @(negedge clk);
    chk("bp_second", out_pc, 64'h204); chk("bp_ready_again", in_ready, 1);
    @(negedge clk);
    chk("bp_third", out_pc, 64'h208); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'h00100093; in_pc = 64'h300; @(negedge clk);
    in_inst = 32'h00200093; in_pc = 64'h304; @(negedge clk);
    flush = 1'b1; in_inst = 32'h00300093; in_pc = 64'h308; @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0); chk("flush_ready", in_ready, 1);
    @(negedge clk);
    chk("flush_dropped", out_valid, 0);
    out_ready = 1'b1;
    issue(32'h00000000, 64'h400);
    chk("illegal", out_illegal, 1);
    chk("illegal_flags", {out_reg_wen, out_jump, out_branch, out_mem_ren, out_mem_wen, out_word}, 0);

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      in_inst   = $urandom;
      if ($urandom_range(0, 9) != 0) in_inst[6:0] = ops[$urandom_range(0, 10)];
      in_pc = {$urandom, $urandom};
      if (c == 2000) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
